// File: rtl/clock_chain_ctrl.sv
`default_nettype none
// ============================================================================
// clock_chain_ctrl : count-enable/load sequencing and button-driven time-set
//                    FSM for a three-slice BCD HH:MM:SS counter chain.
// Revision         : 1.0
// ============================================================================
module clock_chain_ctrl #(
  parameter logic [7:0] HR_WRAP  = 8'h23,
  parameter logic [7:0] HR_RESET = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [7:0] sec_q,
  input  logic [7:0] min_q,
  input  logic [7:0] hr_q,
  input  logic       sec_cout,
  input  logic       min_cout,
  output logic       sec_cin,
  output logic       min_cin,
  output logic       hr_cin,
  output logic       sec_load,
  output logic       min_load,
  output logic       hr_load,
  output logic [7:0] load_data,
  output logic [1:0] mode,
  output logic       blink,
  output logic       day_tick
);

  localparam logic [1:0] S_RUN     = 2'd0;
  localparam logic [1:0] S_SET_HR  = 2'd1;
  localparam logic [1:0] S_SET_MIN = 2'd2;
  localparam logic [1:0] S_SET_SEC = 2'd3;

  logic [1:0] mode_q;
  logic [1:0] mode_d;
  logic       blink_q;
  logic       blink_d;
  logic       day_tick_q;
  logic       day_tick_d;

  logic       w_hold;
  logic       w_inc;
  logic       w_hr_at_wrap;
  logic       w_day_wrap;
  logic       w_unused_slice_bits;

  // Coincident presses: the mode advance wins and the cycle drives nothing.
  assign w_hold       = btn_mode & btn_inc;
  assign w_inc        = btn_inc & ~btn_mode;
  assign w_hr_at_wrap = (hr_q == HR_WRAP);

  // Seconds/minutes values are not needed: their carries come from the slices.
  assign w_unused_slice_bits = ^{sec_q, min_q};

  always_comb begin
    sec_cin    = 1'b0;
    min_cin    = 1'b0;
    hr_cin     = 1'b0;
    sec_load   = 1'b0;
    min_load   = 1'b0;
    hr_load    = 1'b0;
    load_data  = 8'h00;
    w_day_wrap = 1'b0;
    if (!reset && !w_hold) begin
      case (mode_q)
        S_RUN: begin
          sec_cin = tick;
          min_cin = sec_cout;
          if (w_hr_at_wrap && min_cout) begin
            hr_load    = 1'b1;
            load_data  = HR_RESET;
            w_day_wrap = 1'b1;
          end else begin
            hr_cin = min_cout;
          end
        end
        S_SET_HR: begin
          if (w_inc) begin
            if (w_hr_at_wrap) begin
              hr_load   = 1'b1;
              load_data = HR_RESET;
            end else begin
              hr_cin = 1'b1;
            end
          end
        end
        S_SET_MIN: begin
          min_cin = w_inc;
        end
        S_SET_SEC: begin
          sec_load = w_inc;
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    mode_d     = btn_mode ? (mode_q + 2'd1) : mode_q;
    day_tick_d = w_day_wrap;
    blink_d    = blink_q;
    if (btn_mode || (mode_q == S_RUN)) begin
      blink_d = 1'b0;
    end else if (tick) begin
      blink_d = ~blink_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q     <= S_RUN;
      blink_q    <= 1'b0;
      day_tick_q <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      blink_q    <= blink_d;
      day_tick_q <= day_tick_d;
    end
  end

  assign mode     = mode_q;
  assign blink    = blink_q;
  assign day_tick = day_tick_q;

endmodule
`default_nettype wire

// File: tb/tb_clock_chain_ctrl.sv
`default_nettype none
// ============================================================================
// tb_clock_chain_ctrl : directed bench for clock_chain_ctrl with behavioural
//                       BCD mod-60 slices closing the loop.
// Revision            : 1.0
// ============================================================================
module tb_clock_chain_ctrl;

  logic       clk;
  logic       reset;
  logic       tick;
  logic       btn_mode;
  logic       btn_inc;
  logic [7:0] w_sec_q, w_min_q, w_hr_q;
  logic       w_sec_cout, w_min_cout;
  logic       sec_cin, min_cin, hr_cin;
  logic       sec_load, min_load, hr_load;
  logic [7:0] load_data;
  logic [1:0] mode;
  logic       blink;
  logic       day_tick;

  // Direct-drive overrides for table vectors
  logic       direct;
  logic [7:0] v_s, v_m, v_h;
  logic       v_sc, v_mc;

  // Behavioural slices
  logic [7:0] m_sec, m_min, m_hr;
  logic       pre_en;
  logic [7:0] p_sec, p_min, p_hr;

  int n_checks;
  int n_err;

  clock_chain_ctrl #(.HR_WRAP(8'h23), .HR_RESET(8'h00)) dut (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .sec_q    (w_sec_q),
    .min_q    (w_min_q),
    .hr_q     (w_hr_q),
    .sec_cout (w_sec_cout),
    .min_cout (w_min_cout),
    .sec_cin  (sec_cin),
    .min_cin  (min_cin),
    .hr_cin   (hr_cin),
    .sec_load (sec_load),
    .min_load (min_load),
    .hr_load  (hr_load),
    .load_data(load_data),
    .mode     (mode),
    .blink    (blink),
    .day_tick (day_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] bcd_next(input logic [7:0] v);
    if (v == 8'h59) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      m_sec <= 8'h00;
      m_min <= 8'h00;
      m_hr  <= 8'h00;
    end else if (pre_en) begin
      m_sec <= p_sec;
      m_min <= p_min;
      m_hr  <= p_hr;
    end else begin
      if (sec_load)     m_sec <= load_data;
      else if (sec_cin) m_sec <= bcd_next(m_sec);
      if (min_load)     m_min <= load_data;
      else if (min_cin) m_min <= bcd_next(m_min);
      if (hr_load)      m_hr  <= load_data;
      else if (hr_cin)  m_hr  <= bcd_next(m_hr);
    end
  end

  assign w_sec_q    = direct ? v_s  : m_sec;
  assign w_min_q    = direct ? v_m  : m_min;
  assign w_hr_q     = direct ? v_h  : m_hr;
  assign w_sec_cout = direct ? v_sc : ((m_sec == 8'h59) & sec_cin);
  assign w_min_cout = direct ? v_mc : ((m_min == 8'h59) & min_cin);

  logic [13:0] w_strb;
  assign w_strb = {sec_cin, min_cin, hr_cin, sec_load, min_load, hr_load, load_data};

  typedef struct {
    string       name;
    int          nmode;
    logic        t, bm, bi;
    logic [7:0]  s, m, h;
    logic        sc, mc;
    logic [13:0] exp; // {sec_cin,min_cin,hr_cin,sec_load,min_load,hr_load,load_data}
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input string name, input int nmode,
                              input logic t, input logic bm, input logic bi,
                              input logic [7:0] s, input logic [7:0] m, input logic [7:0] h,
                              input logic sc, input logic mc, input logic [13:0] exp);
    vec_t v;
    v.name = name; v.nmode = nmode; v.t = t; v.bm = bm; v.bi = bi;
    v.s = s; v.m = m; v.h = h; v.sc = sc; v.mc = mc; v.exp = exp;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: inputs held through the posedge, cleared after, return at negedge.
  task automatic cyc();
    @(posedge clk);
    #1;
    tick     = 1'b0;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  task automatic preload(input logic [7:0] s, input logic [7:0] m, input logic [7:0] h);
    pre_en = 1'b1; p_sec = s; p_min = m; p_hr = h;
    cyc();
    pre_en = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_err = 0;
    reset = 1'b1; tick = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    direct = 1'b0; v_s = 8'h00; v_m = 8'h00; v_h = 8'h00; v_sc = 1'b0; v_mc = 1'b0;
    pre_en = 1'b0; p_sec = 8'h00; p_min = 8'h00; p_hr = 8'h00;

    // Vector table: decode of cin/load/load_data for each mode
    add("run_tick",       0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, {6'b100000, 8'h00});
    add("run_sec59",      0, 1'b1, 1'b0, 1'b0, 8'h59, 8'h00, 8'h00, 1'b1, 1'b0, {6'b110000, 8'h00});
    add("run_min59",      0, 1'b1, 1'b0, 1'b0, 8'h59, 8'h59, 8'h12, 1'b1, 1'b1, {6'b111000, 8'h00});
    add("run_day_wrap",   0, 1'b1, 1'b0, 1'b0, 8'h59, 8'h59, 8'h23, 1'b1, 1'b1, {6'b110001, 8'h00});
    add("run_idle_h23",   0, 1'b0, 1'b0, 1'b0, 8'h10, 8'h59, 8'h23, 1'b0, 1'b0, {6'b000000, 8'h00});
    add("run_both_btn",   0, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, {6'b000000, 8'h00});
    add("hr_tick_ignore", 1, 1'b1, 1'b0, 1'b0, 8'h59, 8'h00, 8'h05, 1'b0, 1'b0, {6'b000000, 8'h00});
    add("hr_inc",         1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h22, 1'b0, 1'b0, {6'b001000, 8'h00});
    add("hr_inc_wrap",    1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h23, 1'b0, 1'b0, {6'b000001, 8'h00});
    add("hr_mode_inc",    1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h22, 1'b0, 1'b0, {6'b000000, 8'h00});
    add("min_inc59",      2, 1'b0, 1'b0, 1'b1, 8'h00, 8'h59, 8'h04, 1'b0, 1'b1, {6'b010000, 8'h00});
    add("min_tick",       2, 1'b1, 1'b0, 1'b0, 8'h59, 8'h00, 8'h04, 1'b0, 1'b0, {6'b000000, 8'h00});
    add("sec_inc",        3, 1'b0, 1'b0, 1'b1, 8'h37, 8'h00, 8'h00, 1'b0, 1'b0, {6'b000100, 8'h00});
    add("sec_tick",       3, 1'b1, 1'b0, 1'b0, 8'h37, 8'h00, 8'h00, 1'b0, 1'b0, {6'b000000, 8'h00});
    add("sec_mode",       3, 1'b0, 1'b1, 1'b0, 8'h37, 8'h00, 8'h00, 1'b0, 1'b0, {6'b000000, 8'h00});

    @(negedge clk);
    // Reset state
    tick = 1'b1; btn_inc = 1'b1;
    #1 chk("reset_strobes", {18'd0, w_strb}, 32'd0);
    cyc();
    reset = 1'b0;
    chk("reset_mode", {30'd0, mode}, 32'd0);
    chk("reset_blink", {31'd0, blink}, 32'd0);
    chk("reset_day_tick", {31'd0, day_tick}, 32'd0);

    foreach (vecs[k]) begin
      do_reset();
      for (int j = 0; j < vecs[k].nmode; j++) begin
        btn_mode = 1'b1;
        cyc();
      end
      chk({vecs[k].name, "_mode"}, {30'd0, mode}, vecs[k].nmode);
      direct = 1'b1;
      v_s = vecs[k].s; v_m = vecs[k].m; v_h = vecs[k].h; v_sc = vecs[k].sc; v_mc = vecs[k].mc;
      tick = vecs[k].t; btn_mode = vecs[k].bm; btn_inc = vecs[k].bi;
      #1 chk(vecs[k].name, {18'd0, w_strb}, {18'd0, vecs[k].exp});
      tick = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0; direct = 1'b0;
      @(negedge clk);
    end

    // A: 61 ticks from 00:00:00
    do_reset();
    for (int i = 0; i < 61; i++) begin
      tick = 1'b1;
      #1;
      chk("A_sec_cin", {31'd0, sec_cin}, 32'd1);
      chk("A_min_cin", {31'd0, min_cin}, (i == 59) ? 32'd1 : 32'd0);
      cyc();
      chk("A_idle_sec_cin", {31'd0, sec_cin}, 32'd0);
      cyc();
    end
    chk("A_time", {8'd0, m_hr, m_min, m_sec}, 32'h00_0101);

    // B: full carry chain into the day wrap
    preload(8'h58, 8'h59, 8'h23);
    tick = 1'b1;
    cyc();
    chk("B_time_595959", {8'd0, m_hr, m_min, m_sec}, 32'h23_5959);
    tick = 1'b1;
    #1;
    chk("B_hr_load", {31'd0, hr_load}, 32'd1);
    chk("B_hr_cin", {31'd0, hr_cin}, 32'd0);
    chk("B_load_data", {24'd0, load_data}, 32'h00);
    chk("B_day_tick_early", {31'd0, day_tick}, 32'd0);
    cyc();
    chk("B_time_000000", {8'd0, m_hr, m_min, m_sec}, 32'h00_0000);
    chk("B_day_tick", {31'd0, day_tick}, 32'd1);
    cyc();
    chk("B_day_tick_off", {31'd0, day_tick}, 32'd0);

    // C: set hours 22 -> 23 -> 00 -> 01 with ticks dropped
    preload(8'h12, 8'h34, 8'h22);
    btn_mode = 1'b1;
    cyc();
    chk("C_mode", {30'd0, mode}, 32'd1);
    chk("C_blink_entry", {31'd0, blink}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      btn_inc = 1'b1; tick = 1'b1;
      cyc();
      chk("C_hr", {24'd0, m_hr}, (k == 0) ? 32'h23 : ((k == 1) ? 32'h00 : 32'h01));
      chk("C_min_sec", {16'd0, m_min, m_sec}, 32'h3412);
      chk("C_day_tick", {31'd0, day_tick}, 32'd0);
      chk("C_blink", {31'd0, blink}, (k % 2 == 0) ? 32'd1 : 32'd0);
    end

    // D: set minutes wraps 59 -> 00 without carrying into hours
    btn_mode = 1'b1;
    cyc();
    chk("D_mode", {30'd0, mode}, 32'd2);
    chk("D_blink_entry", {31'd0, blink}, 32'd0);
    preload(8'h12, 8'h59, 8'h01);
    btn_inc = 1'b1;
    #1;
    chk("D_min_cin", {31'd0, min_cin}, 32'd1);
    chk("D_hr_cin", {31'd0, hr_cin}, 32'd0);
    cyc();
    chk("D_time", {8'd0, m_hr, m_min, m_sec}, 32'h01_0012);

    // E: set seconds zeroes, then back to RUN and counting resumes
    btn_mode = 1'b1;
    cyc();
    chk("E_mode", {30'd0, mode}, 32'd3);
    preload(8'h37, 8'h00, 8'h01);
    btn_inc = 1'b1;
    cyc();
    chk("E_sec_zero", {24'd0, m_sec}, 32'h00);
    btn_mode = 1'b1;
    cyc();
    chk("E_mode_run", {30'd0, mode}, 32'd0);
    tick = 1'b1;
    cyc();
    chk("E_time", {8'd0, m_hr, m_min, m_sec}, 32'h01_0001);

    // F: coincident buttons in SET_HR, then reset during SET_MIN
    do_reset();
    btn_mode = 1'b1;
    cyc();
    btn_mode = 1'b1; btn_inc = 1'b1;
    cyc();
    chk("F_mode", {30'd0, mode}, 32'd2);
    chk("F_hr", {24'd0, m_hr}, 32'h00);
    preload(8'h09, 8'h07, 8'h05);
    tick = 1'b1;
    cyc();
    chk("F_blink", {31'd0, blink}, 32'd1);
    reset = 1'b1; tick = 1'b1; btn_inc = 1'b1;
    #1 chk("F_reset_strobes", {18'd0, w_strb}, 32'd0);
    cyc();
    reset = 1'b0;
    chk("F_mode_reset", {30'd0, mode}, 32'd0);
    chk("F_blink_reset", {31'd0, blink}, 32'd0);
    chk("F_day_tick_reset", {31'd0, day_tick}, 32'd0);
    chk("F_slices_reset", {8'd0, m_hr, m_min, m_sec}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
